// File: rtl/mips_ctrl_pkg.sv
// Shared encodings for the multicycle MIPS control unit: opcodes, FSM states,
// datapath select codes and the packed control word handed from decode to top.
package mips_ctrl_pkg;

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_J     = 6'b000010;
    localparam logic [5:0] OP_ADDI  = 6'b001000;

    typedef enum logic [3:0] {
        ST_FETCH    = 4'd0,
        ST_DECODE   = 4'd1,
        ST_MEMADR   = 4'd2,
        ST_MEMREAD  = 4'd3,
        ST_MEMWB    = 4'd4,
        ST_MEMWRITE = 4'd5,
        ST_EXECUTE  = 4'd6,
        ST_RTYPE_WB = 4'd7,
        ST_BRANCH   = 4'd8,
        ST_JUMP     = 4'd9,
        ST_ADDI_EX  = 4'd10,
        ST_ADDI_WB  = 4'd11
    } state_e;

    localparam logic [1:0] ALUOP_ADD   = 2'b00;
    localparam logic [1:0] ALUOP_SUB   = 2'b01;
    localparam logic [1:0] ALUOP_FUNCT = 2'b10;

    localparam logic [1:0] SRCB_B       = 2'b00;
    localparam logic [1:0] SRCB_FOUR    = 2'b01;
    localparam logic [1:0] SRCB_SEXT    = 2'b10;
    localparam logic [1:0] SRCB_SEXT_SH = 2'b11;

    localparam logic [1:0] PCSRC_ALU    = 2'b00;
    localparam logic [1:0] PCSRC_ALUOUT = 2'b01;
    localparam logic [1:0] PCSRC_JUMP   = 2'b10;

    typedef struct packed {
        logic       pc_write;
        logic       pc_write_cond;
        logic       iord;
        logic       mem_read;
        logic       mem_write;
        logic       ir_write;
        logic       mem_to_reg;
        logic       reg_dst;
        logic       reg_write;
        logic       alu_src_a;
        logic [1:0] alu_src_b;
        logic [1:0] alu_op;
        logic [1:0] pc_source;
        logic       illegal_op;
    } ctrl_t;

    function automatic logic op_supported(input logic [5:0] op);
        return (op == OP_RTYPE) || (op == OP_LW) || (op == OP_SW) ||
               (op == OP_BEQ)   || (op == OP_J)  || (op == OP_ADDI);
    endfunction

endpackage

// File: rtl/mips_ctrl_decode.sv
// Combinational state -> control word decode; zero latency. Only FETCH strobes
// (IRWrite/PCWrite) depend on mem_ready, so a stalled fetch never loads the IR.
module mips_ctrl_decode
    import mips_ctrl_pkg::*;
(
    input  state_e      state,
    input  logic [5:0]  opcode,
    input  logic        mem_rdy,
    output ctrl_t       ctrl
);

    always_comb begin
        ctrl = '0;
        case (state)
            ST_FETCH: begin
                ctrl.mem_read  = 1'b1;
                ctrl.alu_src_b = SRCB_FOUR;
                ctrl.ir_write  = mem_rdy;
                ctrl.pc_write  = mem_rdy;
            end
            ST_DECODE: begin
                ctrl.alu_src_b  = SRCB_SEXT_SH;
                ctrl.illegal_op = !op_supported(opcode);
            end
            ST_MEMADR, ST_ADDI_EX: begin
                ctrl.alu_src_a = 1'b1;
                ctrl.alu_src_b = SRCB_SEXT;
            end
            ST_MEMREAD: begin
                ctrl.mem_read = 1'b1;
                ctrl.iord     = 1'b1;
            end
            ST_MEMWB: begin
                ctrl.reg_write  = 1'b1;
                ctrl.mem_to_reg = 1'b1;
            end
            ST_MEMWRITE: begin
                ctrl.mem_write = 1'b1;
                ctrl.iord      = 1'b1;
            end
            ST_EXECUTE: begin
                ctrl.alu_src_a = 1'b1;
                ctrl.alu_op    = ALUOP_FUNCT;
            end
            ST_RTYPE_WB: begin
                ctrl.reg_write = 1'b1;
                ctrl.reg_dst   = 1'b1;
            end
            ST_BRANCH: begin
                ctrl.alu_src_a     = 1'b1;
                ctrl.alu_op        = ALUOP_SUB;
                ctrl.pc_write_cond = 1'b1;
                ctrl.pc_source     = PCSRC_ALUOUT;
            end
            ST_JUMP: begin
                ctrl.pc_write  = 1'b1;
                ctrl.pc_source = PCSRC_JUMP;
            end
            ST_ADDI_WB: begin
                ctrl.reg_write = 1'b1;
            end
            default: ctrl = '0;
        endcase
    end

endmodule

// File: rtl/mips_multicycle_ctrl.sv
// Multicycle MIPS main control FSM: 3-5 cycles per instruction plus one per
// mem_ready=0 cycle in FETCH/MEMREAD/MEMWRITE, where the state simply holds.
module mips_multicycle_ctrl
    import mips_ctrl_pkg::*;
#(
    parameter bit MEM_WAIT_EN = 1'b1
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [5:0] opcode,
    input  logic       mem_ready,
    output logic       PCWrite,
    output logic       PCWriteCond,
    output logic       IorD,
    output logic       MemRead,
    output logic       MemWrite,
    output logic       IRWrite,
    output logic       MemtoReg,
    output logic       RegDst,
    output logic       RegWrite,
    output logic       ALUSrcA,
    output logic [1:0] ALUSrcB,
    output logic [1:0] ALUOp,
    output logic [1:0] PCSource,
    output logic       illegal_op,
    output logic [3:0] state_dbg
);

    state_e state_q, state_d;
    ctrl_t  ctrl_raw, ctrl_out;
    logic   mem_rdy;

    assign mem_rdy = MEM_WAIT_EN ? mem_ready : 1'b1;

    always_ff @(posedge clk) begin
        if (reset) state_q <= ST_FETCH;
        else       state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_FETCH:    if (mem_rdy) state_d = ST_DECODE;
            ST_DECODE: begin
                case (opcode)
                    OP_LW, OP_SW: state_d = ST_MEMADR;
                    OP_RTYPE:     state_d = ST_EXECUTE;
                    OP_BEQ:       state_d = ST_BRANCH;
                    OP_J:         state_d = ST_JUMP;
                    OP_ADDI:      state_d = ST_ADDI_EX;
                    default:      state_d = ST_FETCH;
                endcase
            end
            ST_MEMADR: begin
                if (opcode == OP_LW)      state_d = ST_MEMREAD;
                else if (opcode == OP_SW) state_d = ST_MEMWRITE;
                else                      state_d = ST_FETCH;
            end
            ST_MEMREAD:  if (mem_rdy) state_d = ST_MEMWB;
            ST_MEMWRITE: if (mem_rdy) state_d = ST_FETCH;
            ST_EXECUTE:  state_d = ST_RTYPE_WB;
            ST_ADDI_EX:  state_d = ST_ADDI_WB;
            default:     state_d = ST_FETCH;
        endcase
    end

    mips_ctrl_decode u_decode (
        .state   (state_q),
        .opcode  (opcode),
        .mem_rdy (mem_rdy),
        .ctrl    (ctrl_raw)
    );

    // Reset masks every strobe immediately so an abandoned instruction writes nothing.
    assign ctrl_out = reset ? '0 : ctrl_raw;

    assign PCWrite     = ctrl_out.pc_write;
    assign PCWriteCond = ctrl_out.pc_write_cond;
    assign IorD        = ctrl_out.iord;
    assign MemRead     = ctrl_out.mem_read;
    assign MemWrite    = ctrl_out.mem_write;
    assign IRWrite     = ctrl_out.ir_write;
    assign MemtoReg    = ctrl_out.mem_to_reg;
    assign RegDst      = ctrl_out.reg_dst;
    assign RegWrite    = ctrl_out.reg_write;
    assign ALUSrcA     = ctrl_out.alu_src_a;
    assign ALUSrcB     = ctrl_out.alu_src_b;
    assign ALUOp       = ctrl_out.alu_op;
    assign PCSource    = ctrl_out.pc_source;
    assign illegal_op  = ctrl_out.illegal_op;
    assign state_dbg   = state_q;

endmodule

// File: tb/tb_mips_multicycle_ctrl.sv
// Bench for mips_multicycle_ctrl: per-cycle comparison against an instruction-level
// model plus literal latency / strobe-count expectations for directed programs.
module tb_mips_multicycle_ctrl;

    localparam logic [5:0] LW   = 6'b100011;
    localparam logic [5:0] SW   = 6'b101011;
    localparam logic [5:0] RT   = 6'b000000;
    localparam logic [5:0] BEQ  = 6'b000100;
    localparam logic [5:0] JMP  = 6'b000010;
    localparam logic [5:0] ADDI = 6'b001000;
    localparam logic [5:0] BAD  = 6'b111111;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic [5:0] opcode = 6'd0;
    logic       mem_ready = 1'b1;
    logic       PCWrite, PCWriteCond, IorD, MemRead, MemWrite, IRWrite;
    logic       MemtoReg, RegDst, RegWrite, ALUSrcA, illegal_op;
    logic [1:0] ALUSrcB, ALUOp, PCSource;
    logic [3:0] state_dbg;

    int n_checks = 0;
    int n_fail   = 0;

    mips_multicycle_ctrl #(.MEM_WAIT_EN(1'b1)) dut (
        .clk(clk), .reset(reset), .opcode(opcode), .mem_ready(mem_ready),
        .PCWrite(PCWrite), .PCWriteCond(PCWriteCond), .IorD(IorD),
        .MemRead(MemRead), .MemWrite(MemWrite), .IRWrite(IRWrite),
        .MemtoReg(MemtoReg), .RegDst(RegDst), .RegWrite(RegWrite),
        .ALUSrcA(ALUSrcA), .ALUSrcB(ALUSrcB), .ALUOp(ALUOp),
        .PCSource(PCSource), .illegal_op(illegal_op), .state_dbg(state_dbg)
    );

    always #5 clk = ~clk;

    // Instruction-level model: DECODE loads the remaining step list for the opcode;
    // steps 0 (fetch), 3 (read) and 5 (write) repeat while memory is not ready.
    int m_state = 0;
    int pend[$];

    always @(posedge clk) begin
        if (reset) begin
            m_state = 0;
            pend.delete();
        end else if (m_state == 0) begin
            if (mem_ready) m_state = 1;
        end else if ((m_state == 3 || m_state == 5) && !mem_ready) begin
            m_state = m_state;
        end else begin
            if (m_state == 1) begin
                case (opcode)
                    LW:      pend = '{2, 3, 4};
                    SW:      pend = '{2, 5};
                    RT:      pend = '{6, 7};
                    BEQ:     pend = '{8};
                    JMP:     pend = '{9};
                    ADDI:    pend = '{10, 11};
                    default: pend.delete();
                endcase
            end
            if (pend.size() > 0) m_state = pend.pop_front();
            else                 m_state = 0;
        end
    end

    function automatic logic [16:0] exp_outs(input int st, input logic rdy, input logic [5:0] op);
        logic pcw, pcwc, iord, mr, mw, irw, m2r, rd, rw, sa, ill;
        logic [1:0] sb, aop, ps;
        {pcw, pcwc, iord, mr, mw, irw, m2r, rd, rw, sa, ill} = '0;
        sb = 2'b00; aop = 2'b00; ps = 2'b00;
        case (st)
            0:  begin mr = 1; sb = 2'b01; irw = rdy; pcw = rdy; end
            1:  begin sb = 2'b11; ill = !(op inside {RT, LW, SW, BEQ, JMP, ADDI}); end
            2:  begin sa = 1; sb = 2'b10; end
            3:  begin mr = 1; iord = 1; end
            4:  begin rw = 1; m2r = 1; end
            5:  begin mw = 1; iord = 1; end
            6:  begin sa = 1; aop = 2'b10; end
            7:  begin rw = 1; rd = 1; end
            8:  begin sa = 1; aop = 2'b01; pcwc = 1; ps = 2'b01; end
            9:  begin pcw = 1; ps = 2'b10; end
            10: begin sa = 1; sb = 2'b10; end
            11: begin rw = 1; end
            default: ;
        endcase
        return {pcw, pcwc, iord, mr, mw, irw, m2r, rd, rw, sa, sb, aop, ps, ill};
    endfunction

    logic [16:0] act_outs;
    assign act_outs = {PCWrite, PCWriteCond, IorD, MemRead, MemWrite, IRWrite, MemtoReg,
                       RegDst, RegWrite, ALUSrcA, ALUSrcB, ALUOp, PCSource, illegal_op};

    always @(negedge clk) begin
        n_checks++;
        if (reset) begin
            if (act_outs !== 17'd0) begin
                n_fail++;
                $display("FAIL reset_outputs t=%0t actual=%b required=%b", $time, act_outs, 17'd0);
            end
        end else if ({state_dbg, act_outs} !== {m_state[3:0], exp_outs(m_state, mem_ready, opcode)}) begin
            n_fail++;
            $display("FAIL cycle_outputs t=%0t actual state=%0d outs=%b required state=%0d outs=%b",
                     $time, state_dbg, act_outs, m_state, exp_outs(m_state, mem_ready, opcode));
        end
    end

    task automatic chk(input string name, input int act, input int req);
        n_checks++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s actual=%0d required=%0d", name, act, req);
        end
    endtask

    int c_irw, c_pcw, c_pcwc, c_memr, c_memw, c_regw, c_iord, c_ill;

    // Entered #1 after a rising edge with the DUT in FETCH; returns cycles until next FETCH.
    task automatic run_instr(input logic [5:0] op, input int fw, input int mw, output int cyc);
        int f, m;
        bit started;
        f = fw; m = mw; cyc = 0; started = 0;
        {c_irw, c_pcw, c_pcwc, c_memr, c_memw, c_regw, c_iord, c_ill} = '0;
        opcode = op;
        while (!(started && m_state == 0) && cyc < 60) begin
            if (m_state == 0) begin
                mem_ready = (f > 0) ? 1'b0 : 1'b1;
                if (f > 0) f--;
            end else if (m_state == 3 || m_state == 5) begin
                mem_ready = (m > 0) ? 1'b0 : 1'b1;
                if (m > 0) m--;
            end else begin
                mem_ready = 1'b1;
            end
            @(negedge clk);
            c_irw  += int'(IRWrite);
            c_pcw  += int'(PCWrite);
            c_pcwc += int'(PCWriteCond);
            c_memr += int'(MemRead);
            c_memw += int'(MemWrite);
            c_regw += int'(RegWrite);
            c_iord += int'(IorD);
            c_ill  += int'(illegal_op);
            @(posedge clk); #1;
            cyc++;
            if (m_state != 0) started = 1;
        end
        if (cyc >= 60) begin
            n_checks++;
            n_fail++;
            $display("FAIL timeout op=%b actual_cycles=%0d required=<60", op, cyc);
        end
        mem_ready = 1'b1;
    endtask

    initial begin
        int lat;
        int guard;
        repeat (2) @(posedge clk);
        #1 reset = 1'b0;

        run_instr(LW, 0, 0, lat);
        chk("lw_latency", lat, 5);
        chk("lw_irwrite_pulses", c_irw, 1);
        chk("lw_regwrite", c_regw, 1);
        chk("lw_memread", c_memr, 2);

        run_instr(SW, 0, 2, lat);
        chk("sw_latency", lat, 6);
        chk("sw_memwrite_cycles", c_memw, 3);
        chk("sw_iord_cycles", c_iord, 3);
        chk("sw_regwrite", c_regw, 0);

        run_instr(LW, 4, 0, lat);
        chk("fetchwait_latency", lat, 9);
        chk("fetchwait_irwrite", c_irw, 1);
        chk("fetchwait_pcwrite", c_pcw, 1);
        chk("fetchwait_memread", c_memr, 6);

        run_instr(RT, 0, 0, lat);
        chk("r_latency", lat, 4);
        chk("r_regwrite", c_regw, 1);
        run_instr(BEQ, 0, 0, lat);
        chk("beq_latency", lat, 3);
        chk("beq_pcwritecond", c_pcwc, 1);
        run_instr(JMP, 0, 0, lat);
        chk("j_latency", lat, 3);
        chk("j_pcwrite", c_pcw, 2);
        run_instr(ADDI, 0, 0, lat);
        chk("addi_latency", lat, 4);
        chk("addi_regwrite", c_regw, 1);

        run_instr(BAD, 0, 0, lat);
        chk("illegal_latency", lat, 2);
        chk("illegal_pulses", c_ill, 1);
        chk("illegal_regwrite", c_regw, 0);
        chk("illegal_memwrite", c_memw, 0);

        // Abandon a lw stalled in its memory read with a 3-cycle reset.
        opcode = LW;
        mem_ready = 1'b1;
        guard = 0;
        while (m_state != 3 && guard < 20) begin
            @(posedge clk); #1;
            guard++;
        end
        chk("reach_memread", m_state, 3);
        mem_ready = 1'b0;
        @(posedge clk); #1;
        reset = 1'b1;
        repeat (3) begin
            @(posedge clk); #1;
        end
        reset = 1'b0;
        @(negedge clk);
        chk("post_reset_state", int'(state_dbg), 0);
        chk("post_reset_memread", int'(MemRead), 1);
        chk("post_reset_irwrite", int'(IRWrite), 0);
        @(posedge clk); #1;
        mem_ready = 1'b1;
        run_instr(LW, 0, 0, lat);
        chk("post_reset_lw_latency", lat, 5);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout actual=expired required=finish");
        $fatal(1, "timeout");
    end

endmodule
